// File: rtl/bus_ws_responder.sv
// bus_ws_responder: 256-word scratch RAM responder on the core memory bus with
// separate non-sequential/sequential wait-state counts inserted via bus_pause.
module bus_ws_responder #(
    parameter logic [3:0] REGION      = 4'h2,
    parameter int         DEPTH_WORDS = 256,
    parameter int         N_WAIT      = 3,
    parameter int         S_WAIT      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_addr,
    input  logic [1:0]  bus_size,
    input  logic        bus_write,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_pause
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [3:0] NW = 4'(N_WAIT);
    localparam logic [3:0] SW = 4'(S_WAIT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state, state_nx;
    logic [3:0]    wcnt, wcnt_nx, target, be;
    logic          sel, seq_ok, accept, wr_pend, fwd;
    logic [AW-1:0] idx, last_idx, w_idx;
    logic [1:0]    w_size, w_lo;
    logic [31:0]   merged;
    logic [31:0]   ram [DEPTH_WORDS];
    logic          unused_ok;

    assign unused_ok = ^bus_addr[23:AW+2];
    assign sel       = (bus_addr[31:28] == 4'h0) && (bus_addr[27:24] == REGION);
    assign idx       = bus_addr[2 +: AW];
    assign target    = (seq_ok && idx == last_idx + AW'(1)) ? SW : NW;
    // Reset gates the pause combinationally so it drops immediately mid-wait.
    assign bus_pause = sel && !reset && (wcnt != target);
    assign accept    = sel && !reset && (wcnt == target);

    always_comb begin
        state_nx = ST_IDLE;
        wcnt_nx  = 4'd0;
        if (bus_pause) begin
            state_nx = ST_WAIT;
            wcnt_nx  = (state == ST_WAIT ? wcnt : 4'd0) + 4'd1;
        end
    end

    assign be  = w_size == MEM_SIZE_BYTE ? 4'b0001 << w_lo :
                 w_size == MEM_SIZE_HALF ? (w_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign fwd = wr_pend && (w_idx == idx);

    // A read landing on the committing write's word sees the new bytes.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign merged[8*b +: 8] = (fwd && be[b]) ? bus_wdata[8*b +: 8] : ram[idx][8*b +: 8];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wcnt      <= 4'd0;
            seq_ok    <= 1'b0;
            last_idx  <= '0;
            wr_pend   <= 1'b0;
            w_idx     <= '0;
            w_size    <= 2'd0;
            w_lo      <= 2'd0;
            bus_rdata <= 32'h0;
        end else begin
            state     <= state_nx;
            wcnt      <= wcnt_nx;
            seq_ok    <= accept || (sel && seq_ok);
            wr_pend   <= accept && bus_write;
            if (accept) begin
                last_idx <= idx;
                w_idx    <= idx;
                w_size   <= bus_size;
                w_lo     <= bus_addr[1:0];
            end
            bus_rdata <= accept ? (bus_write ? 32'h0 : merged) : (sel ? bus_rdata : 32'h0);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_pend)
            for (int b = 0; b < 4; b++)
                if (be[b]) ram[w_idx][8*b +: 8] <= bus_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_bus_ws_responder.sv
// tb_bus_ws_responder: scoreboard bench; u0 uses default waits, u1 zero waits.
module tb_bus_ws_responder;
    localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] bus_addr = 32'h0, bus_wdata = 32'h0;
    logic [1:0]  bus_size = WORD;
    logic        bus_write = 1'b0;
    logic        dsel = 1'b0;
    logic [31:0] a0, a1, r0, r1, bus_rdata;
    logic        p0, p1, bus_pause;

    int          n_tests = 0, n_fail = 0;
    logic [31:0] mdl [2][256];
    logic [31:0] exp_q [$];
    bit          pend_wr = 0, pend_rd = 0;
    logic [31:0] pend_wdata = 32'h0;

    assign a0        = dsel ? 32'h0 : bus_addr;
    assign a1        = dsel ? bus_addr : 32'h0;
    assign bus_rdata = dsel ? r1 : r0;
    assign bus_pause = dsel ? p1 : p0;

    always #5 clock = ~clock;

    bus_ws_responder u0 (
        .clock(clock), .reset(reset), .bus_addr(a0), .bus_size(bus_size),
        .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_rdata(r0), .bus_pause(p0)
    );

    bus_ws_responder #(.N_WAIT(0), .S_WAIT(0)) u1 (
        .clock(clock), .reset(reset), .bus_addr(a1), .bus_size(bus_size),
        .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_rdata(r1), .bus_pause(p1)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [1:0] sz, logic [1:0] lo);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (sz == WORD || (sz == HALF && (b / 2) == int'(lo[1])) || (sz == BYTE && b == int'(lo)))
                r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic data_phase(string name);
        logic [31:0] e;
        if (pend_rd) begin
            e = exp_q.pop_front();
            n_tests++;
            if (bus_rdata !== e) begin
                n_fail++;
                $display("FAIL %s rdata: got %h expected %h", name, bus_rdata, e);
            end
        end
        if (pend_wr) begin
            n_tests++;
            if (bus_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL %s wr_dphase_rdata: got %h expected 0", name, bus_rdata);
            end
        end
        pend_rd = 0;
        pend_wr = 0;
    endtask

    task automatic issue(string name, logic [31:0] addr, bit wr, logic [1:0] sz, logic [31:0] wd, int exp_p);
        int  p = 0;
        bit  done = 0;
        int  i;
        bus_addr  = addr;
        bus_write = wr;
        bus_size  = sz;
        bus_wdata = pend_wr ? pend_wdata : 32'h0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            if (c == 0) data_phase(name);
            if (bus_pause) p++; else done = 1;
            @(posedge clock); #1;
            bus_wdata = 32'hBAD0_BAD0;
        end
        n_tests++;
        if (!done || p != exp_p) begin
            n_fail++;
            $display("FAIL %s pause: got %0d cycles (accepted=%0d) expected %0d", name, p, done, exp_p);
        end
        if (done) begin
            i = int'(addr[9:2]);
            if (wr) begin
                mdl[dsel][i] = merge(mdl[dsel][i], wd, sz, addr[1:0]);
                pend_wr = 1;
                pend_wdata = wd;
            end else begin
                exp_q.push_back(mdl[dsel][i]);
                pend_rd = 1;
            end
        end
    endtask

    task automatic idle(int n);
        bus_addr  = 32'h0;
        bus_write = 1'b0;
        bus_wdata = pend_wr ? pend_wdata : 32'h0;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            if (c == 0) data_phase("idle");
            else begin
                n_tests++;
                if (bus_rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL idle_rdata: got %h expected 0", bus_rdata);
                end
            end
            @(posedge clock); #1;
            bus_wdata = 32'h0;
        end
    endtask

    task automatic unsel(logic [31:0] addr, int n);
        bus_addr  = addr;
        bus_write = 1'b1;
        bus_size  = WORD;
        bus_wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            n_tests++;
            if (bus_pause !== 1'b0 || bus_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL unsel %h: pause=%b rdata=%h expected 0/0", addr, bus_pause, bus_rdata);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        bus_addr  = 32'h0200_0000;
        bus_write = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if (bus_pause !== 1'b0 || bus_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: pause=%b rdata=%h expected 0/0", bus_pause, bus_rdata);
        end
        reset = 1'b0;
        @(negedge clock);
        n_tests++;
        if (bus_pause !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_after_release: got %b expected 1", bus_pause);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus_pause !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_pause: got %b expected 0", bus_pause);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        issue("first_after_reset", 32'h0200_0000, 1, WORD, 32'hA5A5_0000, 3);
        idle(2);
    endtask

    task automatic test_word();
        issue("word_write", 32'h0200_0010, 1, WORD, 32'hDEAD_BEEF, 3);
        issue("word_read", 32'h0200_0010, 0, WORD, 32'h0, 3);
        idle(2);
    endtask

    task automatic test_half_byte();
        issue("half_base", 32'h0200_0020, 1, WORD, 32'h1111_2222, 3);
        issue("half_write", 32'h0200_0022, 1, HALF, 32'hCAFE_0000, 3);
        issue("half_read", 32'h0200_0020, 0, WORD, 32'h0, 3);
        issue("byte_write", 32'h0200_0021, 1, BYTE, 32'h0000_5500, 3);
        issue("byte_read", 32'h0200_0020, 0, BYTE, 32'h0, 3);
        idle(2);
    endtask

    task automatic test_sequential();
        issue("seq_w40", 32'h0200_0040, 1, WORD, 32'h1111_0040, 3);
        issue("seq_w44", 32'h0200_0044, 1, WORD, 32'h2222_0044, 1);
        issue("seq_w48", 32'h0200_0048, 1, WORD, 32'h3333_0048, 1);
        idle(2);
        issue("seq_r40", 32'h0200_0040, 0, WORD, 32'h0, 3);
        issue("seq_r44", 32'h0200_0044, 0, WORD, 32'h0, 1);
        issue("seq_r48", 32'h0200_0048, 0, WORD, 32'h0, 1);
        idle(2);
        issue("gap_r40", 32'h0200_0040, 0, WORD, 32'h0, 3);
        issue("gap_r44", 32'h0200_0044, 0, WORD, 32'h0, 1);
        idle(1);
        issue("gap_r48", 32'h0200_0048, 0, WORD, 32'h0, 3);
        idle(2);
        issue("wrap_w255", 32'h0200_03FC, 1, WORD, 32'h0FF0_0FF0, 3);
        issue("wrap_w0", 32'h0200_0000, 1, WORD, 32'h0000_0001, 1);
        idle(2);
        issue("wrap_r255", 32'h0200_03FC, 0, WORD, 32'h0, 3);
        issue("wrap_r0", 32'h0200_0000, 0, WORD, 32'h0, 1);
        idle(2);
    endtask

    task automatic test_unselected();
        unsel(32'h0300_0000, 3);
        unsel(32'h1200_0000, 3);
        idle(1);
        issue("unsel_after_r0", 32'h0200_0000, 0, WORD, 32'h0, 3);
        idle(2);
    endtask

    task automatic test_back_to_back();
        dsel = 1'b1;
        idle(2);
        issue("fwd_w50", 32'h0200_0050, 1, WORD, 32'h1234_5678, 0);
        issue("fwd_r50", 32'h0200_0050, 0, WORD, 32'h0, 0);
        issue("alias_r450", 32'h0200_0450, 0, WORD, 32'h0, 0);
        issue("fwd_w60", 32'h0200_0060, 1, WORD, 32'hAAAA_AAAA, 0);
        issue("fwd_b61", 32'h0200_0061, 1, BYTE, 32'h0000_BB00, 0);
        issue("fwd_r60", 32'h0200_0060, 0, WORD, 32'h0, 0);
        for (int k = 0; k < 4; k++)
            issue("b2b_w", 32'h0200_0070 + 32'(4*k), 1, WORD, 32'h7000_0000 + 32'(k * 32'h0101), 0);
        for (int k = 0; k < 4; k++)
            issue("b2b_r", 32'h0200_0070 + 32'(4*k), 0, WORD, 32'h0, 0);
        idle(2);
        dsel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word();
        test_half_byte();
        test_sequential();
        test_unselected();
        test_back_to_back();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
